// File: rtl/clock_display_scan_if.sv
// clock_display_scan_if: time/alarm inputs and scanned display outputs of the alarm-clock display
// Sel/Field/Mode24 pick source, blink field and hour format; CT/ST/Sec carry packed time words;
// seg/an drive the multiplexed digits; days/AM/PM/DBlink drive the indicator lamps.
interface clock_display_scan_if #(parameter int DIGITS = 4);
    logic [1:0] Sel;
    logic [1:0] Field;
    logic Mode24;
    logic [14:0] CT;
    logic [15:0] ST;
    logic [6:0] Sec;
    logic [6:0] seg;
    logic [DIGITS-1:0] an;
    logic [6:0] days;
    logic AM;
    logic PM;
    logic DBlink;
    modport master (
        output Sel, Field, Mode24, CT, ST, Sec,
        input seg, an, days, AM, PM, DBlink
    );
    modport slave (
        input Sel, Field, Mode24, CT, ST, Sec,
        output seg, an, days, AM, PM, DBlink
    );
endinterface

// File: rtl/clock_display_scan.sv
// clock_display_scan: frame-coherent scanned seven-segment display controller for the alarm clock
// Clk/Clr: clock and synchronous active-high reset.
// bus (slave): Sel/Field/Mode24/CT/ST/Sec in; seg/an/days/AM/PM/DBlink out, all registered.
module clock_display_scan #(
    parameter int DIGITS = 4,
    parameter int SCAN_DIV = 250,
    parameter int BLINK_DIV = 500
) (
    input logic Clk,
    input logic Clr,
    clock_display_scan_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam int QW = $clog2(DIGITS);
    localparam logic [QW-1:0] HP = QW'(DIGITS - 2);
    localparam logic [QW-1:0] LAST = QW'(DIGITS - 1);
    localparam logic [6:0] DASH = 7'h01;
    localparam logic [6:0] LET_O = 7'h7E;
    localparam logic [6:0] LET_F = 7'h47;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: enc = 7'h7E;
            4'd1: enc = 7'h30;
            4'd2: enc = 7'h6D;
            4'd3: enc = 7'h79;
            4'd4: enc = 7'h33;
            4'd5: enc = 7'h5B;
            4'd6: enc = 7'h5F;
            4'd7: enc = 7'h70;
            4'd8: enc = 7'h7F;
            4'd9: enc = 7'h7B;
            default: enc = DASH;
        endcase
    endfunction

    logic [PW-1:0] pre;
    logic [QW-1:0] nxt;
    logic [QW-1:0] p;
    logic run;
    logic [BW-1:0] bc;
    logic blank_ph;
    logic [15:0] s_src;
    logic [6:0] s_sec;
    logic [1:0] s_sel;
    logic [1:0] s_field;
    logic s_m24;

    logic tick;
    logic frame;
    logic restart;
    logic blink_end;
    logic [2:0] day;
    logic [4:0] hr;
    logic [4:0] hd;
    logic [1:0] h_t;
    logic [3:0] h_o;
    logic hr_bad;
    logic min_bad;
    logic sec_bad;
    logic off_view;
    logic is_min;
    logic is_hr;
    logic dim;
    logic [6:0] min_seg;
    logic [6:0] sec_seg;
    logic [6:0] hr_seg;
    logic [6:0] seg_n;
    logic [6:0] days_n;
    logic am_n;
    logic pm_n;

    assign tick = pre == PW'(SCAN_DIV - 1);
    // nxt is the position the coming tick will select, so the first tick after reset shows p=0
    assign frame = tick & (nxt == '0);
    assign restart = frame & ({bus.Sel, bus.Field} != {s_sel, s_field});
    assign blink_end = bc == BW'(BLINK_DIV - 1);

    always_comb begin
        day = s_src[14:12];
        hr = s_src[11:7];
        hr_bad = hr > 5'd23;
        min_bad = s_src[3:0] > 4'd9 || s_src[6:4] > 3'd5;
        sec_bad = s_sec[3:0] > 4'd9 || s_sec[6:4] > 3'd5;
        off_view = s_sel[0] & ~s_src[15];
        hd = s_m24 ? hr : hr == 5'd0 ? 5'd12 : hr > 5'd12 ? hr - 5'd12 : hr;
        h_t = hd >= 5'd20 ? 2'd2 : hd >= 5'd10 ? 2'd1 : 2'd0;
        h_o = hd >= 5'd20 ? 4'(hd - 5'd20) : hd >= 5'd10 ? 4'(hd - 5'd10) : hd[3:0];
        is_min = p < QW'(2);
        is_hr = p >= HP;
        dim = s_sel[1] & blank_ph & ((is_min & s_field == 2'b01) | (is_hr & s_field == 2'b10));
        min_seg = min_bad ? DASH : enc(p[0] ? {1'b0, s_src[6:4]} : s_src[3:0]);
        sec_seg = sec_bad ? DASH : enc(p[0] ? {1'b0, s_sec[6:4]} : s_sec[3:0]);
        // hour tens is blanked in 12 h form when it would be a leading zero
        hr_seg = off_view ? (p == HP ? LET_F : LET_O)
               : hr_bad ? DASH
               : p == HP ? enc(h_o)
               : (!s_m24 && h_t == 2'd0) ? 7'h00 : enc({2'b00, h_t});
        seg_n = dim ? 7'h00 : is_min ? min_seg : is_hr ? hr_seg : sec_seg;
        days_n = (day == 3'd7 || (s_sel[1] & s_field == 2'b11 & blank_ph)) ? 7'd0 : 7'd1 << day;
        am_n = ~s_m24 & ~off_view & ~hr_bad & (hr < 5'd12);
        pm_n = ~s_m24 & ~off_view & ~hr_bad & (hr >= 5'd12);
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            pre <= '0;
            nxt <= '0;
            p <= '0;
            run <= 1'b0;
            bc <= '0;
            blank_ph <= 1'b0;
            s_src <= '0;
            s_sec <= '0;
            s_sel <= '0;
            s_field <= '0;
            s_m24 <= 1'b0;
            bus.seg <= '0;
            bus.an <= '1;
            bus.days <= '0;
            bus.AM <= 1'b0;
            bus.PM <= 1'b0;
            bus.DBlink <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                p <= nxt;
                nxt <= nxt == LAST ? '0 : nxt + 1'b1;
                run <= 1'b1;
                bc <= (restart || blink_end) ? '0 : bc + 1'b1;
                blank_ph <= restart ? 1'b0 : blank_ph ^ blink_end;
            end
            if (frame) begin
                s_src <= bus.Sel[0] ? bus.ST : {1'b1, bus.CT};
                s_sec <= bus.Sec;
                s_sel <= bus.Sel;
                s_field <= bus.Field;
                s_m24 <= bus.Mode24;
            end
            // outputs stay dark until the first tick has selected a digit
            bus.seg <= run ? seg_n : '0;
            bus.an <= run ? ~(DIGITS'(1) << p) : '1;
            bus.days <= run ? days_n : '0;
            bus.AM <= run & am_n;
            bus.PM <= run & pm_n;
            bus.DBlink <= run & s_sel[1] & (s_field == 2'b11);
        end
    end
endmodule

// File: tb/tb_clock_display_scan.sv
// tb_clock_display_scan: directed table-driven bench for clock_display_scan (DIGITS=4, SCAN_DIV=2, BLINK_DIV=4)
module tb_clock_display_scan;
    logic Clk = 1'b0;
    logic Clr = 1'b1;
    clock_display_scan_if #(.DIGITS(4)) bus();
    clock_display_scan #(.DIGITS(4), .SCAN_DIV(2), .BLINK_DIV(4)) dut (.Clk(Clk), .Clr(Clr), .bus(bus));
    always #5 Clk = ~Clk;

    int checks = 0;
    int fails = 0;
    logic [6:0] c_seg [4];
    logic [15:0] c_an;
    logic [6:0] c_days;
    logic c_am, c_pm, c_db;

    typedef struct packed {
        logic [1:0] sel;
        logic m24;
        logic [14:0] ct;
        logic [15:0] st;
        logic [27:0] e_seg;
        logic [6:0] e_days;
        logic e_am;
        logic e_pm;
    } vec_t;
    vec_t vt [12];

    function automatic logic [14:0] t(input int d, input int h, input int mt, input int mo);
        return {3'(d), 5'(h), 3'(mt), 4'(mo)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_an(input logic [3:0] v, input logic eq);
        int n = 0;
        while (((bus.an == v) != eq) && n < 40) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            fails++;
            $display("FAIL timeout waiting for an %s %b", eq ? "==" : "!=", v);
        end
    endtask

    task automatic cap();
        wait_an(4'b1110, 1'b1);
        c_seg[0] = bus.seg;
        c_an[3:0] = bus.an;
        c_days = bus.days;
        c_am = bus.AM;
        c_pm = bus.PM;
        c_db = bus.DBlink;
        for (int k = 1; k < 4; k++) begin
            repeat (2) @(negedge Clk);
            c_seg[k] = bus.seg;
            c_an[4*k +: 4] = bus.an;
        end
    endtask

    task automatic settle();
        wait_an(4'b1110, 1'b0);
        wait_an(4'b1110, 1'b1);
        wait_an(4'b1110, 1'b0);
    endtask

    task automatic chk_frame(input string nm, input logic [27:0] e_seg);
        for (int k = 0; k < 4; k++) chk($sformatf("%s seg%0d", nm, k), 32'(c_seg[k]), 32'(e_seg[7*k +: 7]));
        chk({nm, " an"}, 32'(c_an), 32'h7BDE);
    endtask

    task automatic reset_with(input logic [1:0] sel, input logic [1:0] field, input logic m24, input logic [14:0] ct);
        @(negedge Clk);
        Clr = 1'b1;
        bus.Sel = sel;
        bus.Field = field;
        bus.Mode24 = m24;
        bus.CT = ct;
        @(negedge Clk);
        Clr = 1'b0;
    endtask

    initial begin
        bus.Sel = 2'b00;
        bus.Field = 2'b00;
        bus.Mode24 = 1'b0;
        bus.CT = t(3, 0, 0, 5);
        bus.ST = 16'h0;
        bus.Sec = 7'h0;
        vt[0]  = '{2'b00, 1'b0, t(3, 0, 0, 5),  16'h0, {7'h30, 7'h6D, 7'h7E, 7'h5B}, 7'b0001000, 1'b1, 1'b0};
        vt[1]  = '{2'b00, 1'b0, t(3, 9, 0, 5),  16'h0, {7'h00, 7'h7B, 7'h7E, 7'h5B}, 7'b0001000, 1'b1, 1'b0};
        vt[2]  = '{2'b00, 1'b0, t(3, 12, 0, 5), 16'h0, {7'h30, 7'h6D, 7'h7E, 7'h5B}, 7'b0001000, 1'b0, 1'b1};
        vt[3]  = '{2'b00, 1'b0, t(3, 13, 0, 5), 16'h0, {7'h00, 7'h30, 7'h7E, 7'h5B}, 7'b0001000, 1'b0, 1'b1};
        vt[4]  = '{2'b00, 1'b0, t(3, 23, 0, 5), 16'h0, {7'h30, 7'h30, 7'h7E, 7'h5B}, 7'b0001000, 1'b0, 1'b1};
        vt[5]  = '{2'b00, 1'b1, t(3, 9, 0, 5),  16'h0, {7'h7E, 7'h7B, 7'h7E, 7'h5B}, 7'b0001000, 1'b0, 1'b0};
        vt[6]  = '{2'b00, 1'b1, t(6, 23, 5, 9), 16'h0, {7'h6D, 7'h79, 7'h5B, 7'h7B}, 7'b1000000, 1'b0, 1'b0};
        vt[7]  = '{2'b01, 1'b0, t(3, 0, 0, 5),  {1'b0, t(2, 7, 3, 0)}, {7'h7E, 7'h47, 7'h79, 7'h7E}, 7'b0000100, 1'b0, 1'b0};
        vt[8]  = '{2'b01, 1'b0, t(3, 0, 0, 5),  {1'b1, t(2, 7, 3, 0)}, {7'h00, 7'h70, 7'h79, 7'h7E}, 7'b0000100, 1'b1, 1'b0};
        vt[9]  = '{2'b00, 1'b1, t(7, 25, 0, 10), 16'h0, {7'h01, 7'h01, 7'h01, 7'h01}, 7'b0000000, 1'b0, 1'b0};
        vt[10] = '{2'b00, 1'b1, t(1, 0, 6, 0),  16'h0, {7'h7E, 7'h7E, 7'h01, 7'h01}, 7'b0000010, 1'b0, 1'b0};
        vt[11] = '{2'b00, 1'b0, t(0, 11, 4, 8), 16'h0, {7'h30, 7'h30, 7'h33, 7'h7F}, 7'b0000001, 1'b1, 1'b0};

        repeat (3) @(negedge Clk);
        chk("reset seg", 32'(bus.seg), 32'h0);
        chk("reset an", 32'(bus.an), 32'hF);
        chk("reset days", 32'(bus.days), 32'h0);
        chk("reset AM/PM/DBlink", 32'({bus.AM, bus.PM, bus.DBlink}), 32'h0);
        Clr = 1'b0;

        for (int i = 0; i < 12; i++) begin
            bus.Sel = vt[i].sel;
            bus.Field = 2'b00;
            bus.Mode24 = vt[i].m24;
            bus.CT = vt[i].ct;
            bus.ST = vt[i].st;
            settle();
            cap();
            chk_frame($sformatf("vec%0d", i), vt[i].e_seg);
            chk($sformatf("vec%0d days", i), 32'(c_days), 32'(vt[i].e_days));
            chk($sformatf("vec%0d AM", i), 32'(c_am), 32'(vt[i].e_am));
            chk($sformatf("vec%0d PM", i), 32'(c_pm), 32'(vt[i].e_pm));
            chk($sformatf("vec%0d DBlink", i), 32'(c_db), 32'h0);
        end

        bus.Sel = 2'b00;
        bus.Mode24 = 1'b1;
        bus.CT = t(3, 10, 2, 1);
        settle();
        cap();
        chk_frame("midA", {7'h30, 7'h7E, 7'h6D, 7'h30});
        wait_an(4'b1110, 1'b1);
        chk("mid p0 old", 32'(bus.seg), 32'h30);
        bus.CT = t(3, 14, 3, 7);
        repeat (2) @(negedge Clk);
        chk("mid p1 old", 32'(bus.seg), 32'h6D);
        repeat (2) @(negedge Clk);
        chk("mid p2 old", 32'(bus.seg), 32'h7E);
        repeat (2) @(negedge Clk);
        chk("mid p3 old", 32'(bus.seg), 32'h30);
        cap();
        chk_frame("midB", {7'h30, 7'h33, 7'h79, 7'h70});

        bus.CT = t(7, 25, 0, 10);
        settle();
        wait_an(4'b1011, 1'b1);
        Clr = 1'b1;
        @(negedge Clk);
        chk("clr seg", 32'(bus.seg), 32'h0);
        chk("clr an", 32'(bus.an), 32'hF);
        chk("clr days", 32'(bus.days), 32'h0);
        Clr = 1'b0;
        @(negedge Clk);
        chk("post-clr an c1", 32'(bus.an), 32'hF);
        @(negedge Clk);
        chk("post-clr an c2", 32'(bus.an), 32'hF);
        @(negedge Clk);
        chk("post-clr an c3", 32'(bus.an), 32'hE);
        chk("post-clr seg c3", 32'(bus.seg), 32'h01);

        reset_with(2'b10, 2'b01, 1'b1, t(3, 10, 2, 1));
        cap();
        chk_frame("blinkmin f1", {7'h30, 7'h7E, 7'h6D, 7'h30});
        cap();
        chk_frame("blinkmin f2", {7'h30, 7'h7E, 7'h00, 7'h00});
        cap();
        chk_frame("blinkmin f3", {7'h30, 7'h7E, 7'h6D, 7'h30});
        chk("blinkmin DBlink", 32'(c_db), 32'h0);

        reset_with(2'b10, 2'b10, 1'b1, t(3, 10, 2, 1));
        cap();
        chk_frame("blinkhr f1", {7'h30, 7'h7E, 7'h6D, 7'h30});
        cap();
        chk_frame("blinkhr f2", {7'h00, 7'h00, 7'h6D, 7'h30});

        reset_with(2'b10, 2'b11, 1'b1, t(3, 10, 2, 1));
        cap();
        chk("blinkday f1 days", 32'(c_days), 32'h08);
        chk("blinkday f1 DBlink", 32'(c_db), 32'h1);
        cap();
        chk("blinkday f2 days", 32'(c_days), 32'h00);
        chk("blinkday f2 DBlink", 32'(c_db), 32'h1);
        chk_frame("blinkday f2", {7'h30, 7'h7E, 7'h6D, 7'h30});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
